signal_stable_detect: RTL and testbench

SIGNAL_STABLE_DETECT -- requirements
Module: signal_stable_detect

---
 rtl/sig_detect_pkg.sv | 8 +
 rtl/sync_edge_detect.sv | 22 ++
 rtl/signal_stable_detect.sv | 94 +++++++++
 tb/tb_signal_stable_detect.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sig_detect_pkg.sv
// sig_detect_pkg: shared FSM state type and default parameters for signal_stable_detect
package sig_detect_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  localparam int DEF_CNT_WIDTH    = 24;
  localparam int DEF_STABLE_COUNT = 4;
  localparam int DEF_TOL_SHIFT    = 4;
  localparam int DEF_TIMEOUT      = 2**20;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchroniser with registered rising-edge pulse
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);
  logic s1, q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b0;
      level <= 1'b0;
      q     <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1    <= d;
      level <= s1;
      q     <= level;
      rise  <= level & ~q;
    end
endmodule

// File: rtl/signal_stable_detect.sv
// signal_stable_detect: measures square-wave period and flags lock on a steady period
module signal_stable_detect
  import sig_detect_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int TOL_SHIFT    = DEF_TOL_SHIFT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 signal_in,
  output logic                 sync_signal_in,
  output logic                 stable,
  output logic                 trig,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid
);
  localparam int MW = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, prev, prev_n, period_n;
  logic [MW-1:0] mc, mc_n;
  logic prev_v, prev_v_n, pv_n, hit, tmo;
  logic signed [CNT_WIDTH:0] diff;
  logic [CNT_WIDTH:0] adiff;

  sync_edge_detect u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (signal_in),
    .level (sync_signal_in),
    .rise  (trig)
  );

  assign stable = state == LOCKED;

  always_comb begin
    state_n  = state;
    prev_n   = prev;
    prev_v_n = prev_v;
    mc_n     = mc;
    period_n = period;
    pv_n     = 1'b0;
    cnt_n    = trig ? CNT_WIDTH'(1) : (cnt == MAX ? cnt : cnt + 1'b1);
    diff     = $signed({1'b0, cnt}) - $signed({1'b0, prev});
    adiff    = diff[CNT_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    // a saturated count is not a real measurement and must never lock
    hit      = cnt != MAX && adiff <= {1'b0, prev >> TOL_SHIFT};
    tmo      = !trig && 64'(cnt) + 64'd1 == 64'(TIMEOUT);
    if (trig) begin
      if (state == IDLE) begin
        state_n  = MEASURE;
        mc_n     = '0;
        prev_v_n = 1'b0;
      end else begin
        period_n = cnt;
        pv_n     = 1'b1;
        prev_n   = cnt;
        prev_v_n = 1'b1;
        if (!prev_v || !hit) begin
          mc_n    = '0;
          state_n = MEASURE;
        end else if (state == MEASURE) begin
          mc_n = mc + 1'b1;
          if (mc_n == MW'(STABLE_COUNT)) state_n = LOCKED;
        end
      end
    end else if (state != IDLE && tmo) begin
      state_n  = IDLE;
      prev_v_n = 1'b0;
      mc_n     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= '0;
      prev_v       <= 1'b0;
      mc           <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      prev         <= prev_n;
      prev_v       <= prev_v_n;
      mc           <= mc_n;
      period       <= period_n;
      period_valid <= pv_n;
    end
endmodule

// File: tb/tb_signal_stable_detect.sv
// tb_signal_stable_detect: edge-timeline reference model, vector table and directed corner cases
module tb_signal_stable_detect;
  localparam int W = 24, SC = 4, TS = 4, TO = 1000;
  localparam int MAXV = 2**W - 1;

  logic clk = 1'b0, rst_n = 1'b0, signal_in = 1'b0, sig2 = 1'b0;
  logic sync_signal_in, stable, trig, period_valid;
  logic [W-1:0] period;
  logic sync2, stable2, trig2, pv2;
  logic [7:0] period2;

  always #5 clk = ~clk;

  signal_stable_detect #(.CNT_WIDTH(W), .STABLE_COUNT(SC), .TOL_SHIFT(TS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .sync_signal_in(sync_signal_in),
    .stable(stable), .trig(trig), .period(period), .period_valid(period_valid));

  signal_stable_detect #(.CNT_WIDTH(8), .STABLE_COUNT(SC), .TOL_SHIFT(TS), .TIMEOUT(100000)) dut2 (
    .clk(clk), .rst_n(rst_n), .signal_in(sig2), .sync_signal_in(sync2),
    .stable(stable2), .trig(trig2), .period(period2), .period_valid(pv2));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: works on sampled-edge timestamps and period lengths
  bit samp[$];
  int n, last_t, ms, runs, prevp;
  bit have_prev, e_pv, e_trig, e_sync;
  int e_period;

  function automatic bit get(input int k);
    return (k < 1) ? 1'b0 : samp[k-1];
  endfunction

  task automatic model_reset();
    samp.delete();
    n = 0; last_t = 0; ms = 0; runs = 0; prevp = 0;
    have_prev = 0; e_period = 0; e_pv = 0;
  endtask

  task automatic model_step(input bit s);
    int p, d;
    bit hit;
    samp.push_back(s);
    n++;
    e_sync = get(n-1);
    e_trig = get(n-2) && !get(n-3);
    e_pv = 0;
    if (get(n-3) && !get(n-4)) begin
      p = n - 1 - last_t;
      if (p > MAXV) p = MAXV;
      if (ms == 0) begin
        ms = 1; have_prev = 0; runs = 0;
      end else begin
        e_period = p; e_pv = 1;
        d = p > prevp ? p - prevp : prevp - p;
        hit = p != MAXV && d <= (prevp >> TS);
        if (!have_prev) runs = 0;
        else if (ms == 2) begin
          if (!hit) begin ms = 1; runs = 0; end
        end else if (!hit) runs = 0;
        else begin
          runs++;
          if (runs == SC) ms = 2;
        end
        prevp = p; have_prev = 1;
      end
      last_t = n - 1;
    end else if (ms != 0 && n - last_t == TO) begin
      ms = 0; have_prev = 0; runs = 0;
    end
  endtask

  task automatic tick(input bit s);
    signal_in = s;
    @(posedge clk);
    if (rst_n) model_step(s);
    #1;
    if (rst_n) begin
      chk("m_sync", sync_signal_in, e_sync);
      chk("m_trig", trig, e_trig);
      chk("m_stable", stable, ms == 2);
      chk("m_period", period, e_period);
      chk("m_pvalid", period_valid, e_pv);
    end
  endtask

  task automatic wave(input int gap);
    for (int i = 0; i < gap; i++) tick(i < gap / 2);
  endtask

  task automatic wait_trig(input string name);
    int w = 0;
    while (!trig && w < 8) begin
      tick(1);
      w++;
    end
    chk(name, trig, 1);
  endtask

  typedef struct {int gap; bit st; int per;} vec_t;
  vec_t tbl[24];

  initial begin
    tbl[0]  = '{100, 0, 0};   tbl[1]  = '{100, 0, 100}; tbl[2]  = '{100, 0, 100};
    tbl[3]  = '{100, 0, 100}; tbl[4]  = '{100, 0, 100}; tbl[5]  = '{106, 1, 100};
    tbl[6]  = '{113, 1, 106}; tbl[7]  = '{200, 0, 113}; tbl[8]  = '{200, 0, 200};
    tbl[9]  = '{200, 0, 200}; tbl[10] = '{200, 0, 200}; tbl[11] = '{200, 0, 200};
    tbl[12] = '{100, 1, 200}; tbl[13] = '{100, 0, 100}; tbl[14] = '{100, 0, 100};
    tbl[15] = '{100, 0, 100}; tbl[16] = '{100, 0, 100}; tbl[17] = '{94, 1, 100};
    tbl[18] = '{100, 1, 94};  tbl[19] = '{100, 0, 100}; tbl[20] = '{100, 0, 100};
    tbl[21] = '{100, 0, 100}; tbl[22] = '{100, 0, 100}; tbl[23] = '{100, 1, 100};

    model_reset();
    repeat (3) tick(0);
    chk("rst_stable", stable, 0);
    chk("rst_trig", trig, 0);
    chk("rst_period", period, 0);
    chk("rst_pvalid", period_valid, 0);
    chk("rst_sync", sync_signal_in, 0);
    rst_n = 1'b1;

    // each record: rising edge, check 4 clocks later, then gap clocks to the next edge
    for (int k = 0; k < 24; k++)
      for (int i = 0; i < tbl[k].gap; i++) begin
        tick(i < tbl[k].gap / 2);
        if (i == 3) begin
          chk($sformatf("tbl%0d_stable", k), stable, tbl[k].st);
          chk($sformatf("tbl%0d_period", k), period, tbl[k].per);
        end
      end

    // freeze while locked: stable drops exactly TO clocks after the last trig
    tick(1);
    wait_trig("to_trig_seen");
    chk("to_locked", stable, 1);
    for (int i = 1; i < TO; i++) tick(i < 50);
    chk("to_before", stable, 1);
    tick(0);
    chk("to_stable", stable, 0);
    chk("to_period", period, 100);

    // input high across reset release counts as a rising edge
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick(1);
    rst_n = 1'b1;
    tick(1); chk("rel_trig1", trig, 0);
    tick(1); chk("rel_trig2", trig, 0);
    tick(1); chk("rel_trig3", trig, 1);
    tick(1); chk("rel_trig4", trig, 0);
    chk("rel_stable", stable, 0);

    for (int k = 0; k < 120; k++) begin
      int r, g;
      r = $urandom_range(0, 99);
      if (r < 10) repeat (TO + 100) tick(0);
      else begin
        g = r < 80 ? 94 + $urandom_range(0, 12) : $urandom_range(20, 300);
        wave(g);
      end
    end

    // asynchronous reset in the middle of lock
    repeat (7) wave(100);
    tick(1);
    wait_trig("ar_trig_seen");
    chk("ar_locked", stable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_stable", stable, 0);
    chk("ar_trig", trig, 0);
    chk("ar_period", period, 0);
    chk("ar_sync", sync_signal_in, 0);
    chk("ar_stable2", stable2, 0);
    repeat (2) tick(0);
    model_reset();
    rst_n = 1'b1;

    // narrow counter: saturated periods never match
    for (int i = 0; i < 14; i++) begin
      int g, pg;
      g = i < 7 ? 200 : 300;
      pg = (i == 0) ? 0 : ((i - 1) < 7 ? 200 : 255);
      for (int j = 0; j < g; j++) begin
        sig2 = j < g / 2;
        tick(0);
        if (j == 3) begin
          chk($sformatf("sat%0d_stable", i), stable2, i >= 5 && i <= 7);
          chk($sformatf("sat%0d_period", i), period2, pg);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
